// File: rtl/ysyx_23060240_trap_pkg.sv
// Shared constants and state encoding for the trap sequencer.
// CSR addresses, cause codes, mstatus bit positions and the FSM state type.
package ysyx_23060240_trap_pkg;

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMtvec   = 12'h305;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;

   localparam logic [31:0] CauseEcallM = 32'd11;
   localparam logic [31:0] CauseMtimer = 32'h8000_0007;

   localparam int unsigned MieBit  = 3;
   localparam int unsigned MpieBit = 7;
   localparam int unsigned MppLo   = 11;
   localparam int unsigned MppHi   = 12;

   typedef enum logic [2:0] {
      StIdle,
      StTEpc,
      StTCause,
      StTMst,
      StMEpc,
      StMMst,
      StRedir
   } trap_state_e;

endpackage

// File: rtl/ysyx_23060240_mstatus_upd.sv
// Combinational mstatus transform: trap entry (mret = 0) or return (mret = 1).
module ysyx_23060240_mstatus_upd
   import ysyx_23060240_trap_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            mret,
   input  logic [XLEN-1:0] cur,
   output logic [XLEN-1:0] nxt
);

   always_comb begin
      nxt = cur;
      nxt[MppHi:MppLo] = 2'b11;
      if (mret) begin
         nxt[MieBit]  = cur[MpieBit];
         nxt[MpieBit] = 1'b1;
      end else begin
         nxt[MpieBit] = cur[MieBit];
         nxt[MieBit]  = 1'b0;
      end
   end

endmodule

// File: rtl/ysyx_23060240_trap_ctrl.sv
// Trap sequencer owning the CSR write port: serialises ecall/mret updates and redirects the IFU.
// Optional machine-timer interrupt entry is enabled by defining YSYX_23060240_TRAP_IRQ_EN.
module ysyx_23060240_trap_ctrl
   import ysyx_23060240_trap_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_valid,
   input  logic [XLEN-1:0] pc,
   input  logic            is_ecall,
   input  logic            is_mret,
   input  logic            csr_wen_in,
   input  logic [11:0]     csr_waddr_in,
   input  logic [XLEN-1:0] csr_wdata_in,
   input  logic [XLEN-1:0] csr_rdata,
   output logic            csr_ren,
   output logic [11:0]     csr_raddr,
   output logic            csr_wen,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready,
`ifdef YSYX_23060240_TRAP_IRQ_EN
   input  logic            irq_mtip,
   input  logic [XLEN-1:0] npc,
`endif
   output logic            busy
);

   trap_state_e     state_q, state_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] tvec_q, tvec_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            ret_q, ret_d;
   logic            mie_q, mie_d;

   logic            upd_mret;
   logic [XLEN-1:0] upd_out;

   localparam logic [XLEN-1:0] TvecMask = {{(XLEN-2){1'b1}}, 2'b00};

   assign upd_mret = (state_q == StMMst);

   ysyx_23060240_mstatus_upd #(
      .XLEN (XLEN)
   ) u_mstatus_upd (
      .mret (upd_mret),
      .cur  (csr_rdata),
      .nxt  (upd_out)
   );

   always_comb begin
      state_d        = state_q;
      epc_d          = epc_q;
      cause_d        = cause_q;
      tvec_d         = tvec_q;
      tgt_d          = tgt_q;
      ret_d          = ret_q;
      mie_d          = mie_q;
      csr_ren        = 1'b0;
      csr_raddr      = '0;
      csr_wen        = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      unique case (state_q)
         StIdle: begin
            if (inst_valid) begin
               if (is_ecall) begin
                  epc_d   = pc;
                  cause_d = XLEN'(CauseEcallM);
                  ret_d   = 1'b0;
                  state_d = StTEpc;
               end else if (is_mret) begin
                  ret_d   = 1'b1;
                  state_d = StMEpc;
               end else begin
                  csr_wen   = csr_wen_in;
                  csr_waddr = csr_waddr_in;
                  csr_wdata = csr_wdata_in;
`ifdef YSYX_23060240_TRAP_IRQ_EN
                  // Interrupt is taken after this instruction, so it returns to npc.
                  if (irq_mtip && mie_q) begin
                     epc_d   = npc;
                     cause_d = XLEN'(CauseMtimer);
                     ret_d   = 1'b0;
                     state_d = StTEpc;
                  end
`endif
               end
            end
         end
         StTEpc: begin
            csr_wen   = 1'b1;
            csr_waddr = CsrMepc;
            csr_wdata = epc_q;
            state_d   = StTCause;
         end
         StTCause: begin
            csr_wen   = 1'b1;
            csr_waddr = CsrMcause;
            csr_wdata = cause_q;
            csr_ren   = 1'b1;
            csr_raddr = CsrMtvec;
            tvec_d    = csr_rdata;
            state_d   = StTMst;
         end
         StTMst, StMMst: begin
            csr_ren   = 1'b1;
            csr_raddr = CsrMstatus;
            csr_wen   = 1'b1;
            csr_waddr = CsrMstatus;
            csr_wdata = upd_out;
            state_d   = StRedir;
         end
         StMEpc: begin
            csr_ren   = 1'b1;
            csr_raddr = CsrMepc;
            tgt_d     = csr_rdata;
            state_d   = StMMst;
         end
         StRedir: begin
            redirect_valid = 1'b1;
            redirect_pc    = ret_q ? tgt_q : (tvec_q & TvecMask);
            if (redirect_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (csr_wen && (csr_waddr == CsrMstatus)) begin
         mie_d = csr_wdata[MieBit];
      end

      // Reset silences every request in the same cycle; nothing escapes while it is held.
      if (rst) begin
         csr_ren        = 1'b0;
         csr_raddr      = '0;
         csr_wen        = 1'b0;
         csr_waddr      = '0;
         csr_wdata      = '0;
         redirect_valid = 1'b0;
         redirect_pc    = '0;
      end
   end

   assign busy = (state_q != StIdle) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         epc_q   <= '0;
         cause_q <= '0;
         tvec_q  <= '0;
         tgt_q   <= '0;
         ret_q   <= 1'b0;
         mie_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         tvec_q  <= tvec_d;
         tgt_q   <= tgt_d;
         ret_q   <= ret_d;
         mie_q   <= mie_d;
      end
   end

endmodule

// File: doc/ysyx_23060240_trap_ctrl.md
# ysyx_23060240_trap_ctrl

Trap sequencer in front of the CSR file. Owns the CSR file's single write port and serialises the multi-register updates required by `ecall` and `mret` (and, optionally, machine-timer interrupts). Forwards ordinary `csrw`/`csrs` commits to the CSR file and issues a PC redirect to the IFU. Sits between commit (WBU) and the CSR file; stalls issue via `busy` while a sequence is running.

## Interface
Parameters:
- `XLEN`, default 32: data and PC width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `inst_valid` in 1: one instruction commits this cycle.
- `pc` in XLEN: PC of the committing instruction.
- `is_ecall`, `is_mret` in 1 each: committing instruction class.
- `csr_wen_in` in 1, `csr_waddr_in` in 12, `csr_wdata_in` in XLEN: CSR write requested by the committing instruction.
- `csr_rdata` in XLEN: combinational read data from the CSR file.
- `csr_ren` out 1, `csr_raddr` out 12: CSR read port request.
- `csr_wen` out 1, `csr_waddr` out 12, `csr_wdata` out XLEN: CSR file write port.
- `redirect_valid` out 1, `redirect_pc` out XLEN, `redirect_ready` in 1: IFU redirect handshake.
- `busy` out 1: high whenever state ≠ IDLE; upstream holds commit.
- `irq_mtip` in 1, `npc` in XLEN: present only with `YSYX_23060240_TRAP_IRQ_EN`.

## Operation
- States: IDLE, T_EPC, T_CAUSE, T_MST, M_EPC, M_MST, REDIR.
- In IDLE with `inst_valid`, the trap source is chosen by priority: `is_ecall` > `is_mret` > irq (when compiled in) > plain.
  - When both `is_ecall` and `is_mret` are set, the instruction is treated as `ecall`.
- ecall path:
  - IDLE latches `pc` → `epc_q` and 11 → `cause_q`.
  - T_EPC writes 0x341 ← `epc_q`.
  - T_CAUSE writes 0x342 ← `cause_q`, and reads 0x305 to latch `tvec_q`.
  - T_MST does a read-modify-write of 0x300: MPIE ← MIE, MIE ← 0, MPP ← 2'b11, all other bits unchanged.
  - Then REDIR with `redirect_pc` = `tvec_q & ~3`.
- mret path:
  - M_EPC reads 0x341 and latches it into `tgt_q`.
  - M_MST does a read-modify-write of 0x300: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - Then REDIR with `redirect_pc` = `tgt_q`.
- Plain commit in IDLE: `csr_wen`/`csr_waddr`/`csr_wdata` are passed through combinationally from the `_in` signals, with no state change.
- `inst_valid` outside IDLE is ignored; holding commit while `busy` is the upstream's responsibility.
- Any `csr_wen_in` on an ecall/mret commit is dropped.
- REDIR: `redirect_valid` = 1 and is held until `redirect_ready`. `redirect_pc` stays stable while waiting. Exit to IDLE on the handshake cycle.
- The controller keeps a 1-bit `mie_q` shadow of mstatus.MIE. It is updated on every write to 0x300 it issues, both pass-through and RMW.

## Timing
- Reset values:
  - State: IDLE.
  - `busy`, `redirect_valid`, `csr_wen`, `csr_ren`: 0.
  - `redirect_pc`, `csr_waddr`, `csr_wdata`, `csr_raddr`: 0.
  - `epc_q`, `cause_q`, `tvec_q`, `tgt_q`: 0. `mie_q`: 0.
- ecall accepted in cycle 0:
  - CSR writes land on the edges ending cycles 1 (mepc), 2 (mcause) and 3 (mstatus).
  - `redirect_valid` rises in cycle 4.
  - With `redirect_ready` = 1, IDLE is reached in cycle 5.
- mret accepted in cycle 0: mepc read in cycle 1, mstatus written in cycle 2, `redirect_valid` in cycle 3.
- Pass-through write takes 0 cycles (combinational) and commits on the same edge.
- Exactly one write per cycle, never two.
- `rst` in any state returns the block to IDLE on the next edge.
  - Writes already performed are not undone.
  - No redirect is issued and `redirect_valid` drops immediately.

## Configuration
- `YSYX_23060240_TRAP_IRQ_EN` defined:
  - `irq_mtip` and `npc` ports exist.
  - In IDLE, `inst_valid & irq_mtip & mie_q` on a non-ecall/mret commit takes the ecall path with `epc_q` = `npc` and `cause_q` = 32'h8000_0007.
  - The instruction's own `csr_wen_in` still passes through in that cycle.
- Macro undefined: the ports are absent and there is no interrupt path.

## Structure
- Shared package `ysyx_23060240_trap_pkg` holds:
  - CSR address constants (0x300, 0x305, 0x341, 0x342).
  - Cause codes (11, 0x8000_0007).
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11).
  - The state enum.
- One sub-module, `ysyx_23060240_mstatus_upd`: combinational trap-entry/mret transform of mstatus, selected by a mode bit.

## Test plan
- ecall at `pc` = 0x8000_0100, mtvec = 0x8000_0005, mstatus = 0x1808:
  - Writes in order: mepc = 0x8000_0100, mcause = 11, mstatus = 0x1880.
  - `redirect_pc` = 0x8000_0004 in cycle 4.
- mret with mepc = 0x8000_0104, mstatus = 0x1880: mstatus → 0x1888, `redirect_pc` = 0x8000_0104 in cycle 3.
- `redirect_ready` held low for 5 cycles in REDIR → `redirect_valid` stays high with `redirect_pc` stable; returns to IDLE 1 cycle after ready.
- Plain `csrw` 0x305 ← 0x8000_0000 → `csr_wen` = 1 in the same cycle, `busy` = 0; simultaneous `is_ecall` + `is_mret` → ecall sequence.
- `rst` asserted during T_CAUSE → IDLE next cycle, no mstatus write, no redirect.
- IRQ_EN: mstatus write setting MIE, then `irq_mtip` = 1 with `npc` = 0x8000_0200 → mepc = 0x8000_0200, mcause = 0x8000_0007.
